nano_mem_arbiter: RTL
=====================

Name: nano_mem_arbiter

Overview:
- Two-port arbiter sharing the single 256x16 NanoCPU memory between requester A (NanoCPU) and requester B (program loader / debug host).
- Round-robin arbitration with a req/ack handshake per port; drives the memory's ce/we/address/dataW and captures dataR.
- Sits between the CPU bus and the memory array.
- Memory model: combinational read, write at posedge ck when we=1.

Parameters:
- AW, 8, address width (memory depth 2^AW)
- DW, 16, data width

Ports:
- ck  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-low reset (0 = reset, sampled on posedge ck)
- req_a  in  1  port A access request, held until ack_a
- we_a  in  1  port A write enable (1 = write, 0 = read), stable while req_a=1
- addr_a  in  AW  port A address, stable while req_a=1
- wdata_a  in  DW  port A write data, stable while req_a=1
- ack_a  out  1  one-cycle completion pulse for port A
- rdata_a  out  DW  port A read data, valid in the ack_a cycle and held until the next A read completes
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b  same as port A, for port B
- mem_ce  out  1  memory chip enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data (combinational from mem_addr)

Behaviour:
- FSM states IDLE, ACCESS, RESP; all outputs registered.
- Reset (rst=0 at posedge):
  - state=IDLE, last_grant=B (so A wins the first tie).
  - mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ack_a=ack_b=0, rdata_a=rdata_b=0.
- IDLE, cycle N:
  - No req: stay in IDLE; mem_ce=mem_we=0.
  - One req: grant that port.
  - Both req: grant the port not equal to last_grant.
  - On grant, at the end of N: register mem_addr/mem_we/mem_wdata from the winner, set mem_ce=1, record winner in last_grant, go to ACCESS.
- ACCESS, cycle N+1:
  - Memory sees ce=1.
  - Write: memory captures at the end of N+1.
  - Read: mem_rdata sampled at the end of N+1 into rdata of the winner. The other port's rdata is unchanged.
  - At the end of N+1: mem_ce=mem_we=0, set ack of the winner, go to RESP.
- RESP, cycle N+2:
  - Winner's ack=1 for exactly this cycle; no arbitration.
  - Next state is IDLE; ack cleared at the end of N+2.
- Latency and throughput:
  - Request-to-ack latency is 2 cycles.
  - One access per 3 cycles.
  - Under continuous requests from both ports, grants strictly alternate A, B, A, ...
- Handshake:
  - A requester deasserts req in or after its ack cycle.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request.
  - req deasserted before ack is a protocol violation; the access already granted still completes.
  - mem_addr/mem_wdata hold their last values when mem_ce=0.
- Reset mid-operation:
  - rst=0 sampled while in ACCESS: the write already presented in that cycle still lands at that edge (memory is not reset), but no ack is issued and rdata is not updated.
  - rst=0 sampled while in RESP: ack still appears in that cycle and is cleared at the edge.
- Address wrap: addresses are AW-bit; no range checks.

Optional Feature:
- Macro NANO_ARB_STATS_EN.
- When defined, adds outputs grant_cnt_a and grant_cnt_b, each 16 bits:
  - Each counts grants to its port, incrementing on the IDLE->ACCESS transition.
  - Saturates at 0xFFFF; cleared by reset.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Port A read, mem[30]=0x000A preloaded, req_a at cycle N -> mem_ce=1, mem_addr=30 in N+1; ack_a=1, rdata_a=0x000A in N+2; ack_b stays 0.
- req_a and req_b both asserted in the first IDLE after reset -> A granted first (ack_a at N+2), B granted next (ack_b at N+5), with no overlap of mem_ce.
- Port B writes 0x1234 to addr 0x0F, then port A reads 0x0F -> mem_we=1 only in B's ACCESS cycle; rdata_a=0x1234 at A's ack.
- Both ports request continuously for 6 accesses -> grant order A,B,A,B,A,B; ack pulses exactly 3 cycles apart.
- rst=0 during a port A ACCESS write of 0xBEEF to addr 5 -> mem[5]=0xBEEF; no ack_a; all outputs 0 next cycle; FSM back in IDLE.
- With NANO_ARB_STATS_EN defined: 3 A grants and 2 B grants -> grant_cnt_a=3, grant_cnt_b=2; after rst=0 both read 0.

Source files
------------

// File: rtl/nano_mem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port 256x16 NanoCPU memory.
// Optional grant statistics are enabled by defining NANO_ARB_STATS_EN.
module nano_mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata_b,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef NANO_ARB_STATS_EN
    ,
    output logic [15:0]   grant_cnt_a,
    output logic [15:0]   grant_cnt_b
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;

    state_t        state, state_nxt;
    port_t         last_grant, last_grant_nxt;
    port_t         win;
    logic          grant_vld;
    logic          mem_ce_nxt, mem_we_nxt, ack_a_nxt, ack_b_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt, rdata_a_nxt, rdata_b_nxt;

    // Round-robin pick: on a tie the port that did not win last time goes first.
    always_comb begin
        grant_vld = req_a | req_b;
        win       = PORT_A;
        if (req_a && req_b)
            win = (last_grant == PORT_A) ? PORT_B : PORT_A;
        else if (req_b)
            win = PORT_B;
    end

    always_ff @(posedge ck) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state      <= IDLE;
            last_grant <= PORT_B;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            rdata_a    <= '0;
            rdata_b    <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            mem_ce     <= mem_ce_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            ack_a      <= ack_a_nxt;
            ack_b      <= ack_b_nxt;
            rdata_a    <= rdata_a_nxt;
            rdata_b    <= rdata_b_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = grant_vld ? ACCESS : IDLE;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        last_grant_nxt = last_grant;
        mem_ce_nxt     = 1'b0;
        mem_we_nxt     = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        ack_a_nxt      = 1'b0;
        ack_b_nxt      = 1'b0;
        rdata_a_nxt    = rdata_a;
        rdata_b_nxt    = rdata_b;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    mem_ce_nxt     = 1'b1;
                    mem_we_nxt     = (win == PORT_A) ? we_a    : we_b;
                    mem_addr_nxt   = (win == PORT_A) ? addr_a  : addr_b;
                    mem_wdata_nxt  = (win == PORT_A) ? wdata_a : wdata_b;
                    last_grant_nxt = win;
                end
            end
            ACCESS: begin
                // last_grant already holds the port being served in this cycle.
                ack_a_nxt = (last_grant == PORT_A);
                ack_b_nxt = (last_grant == PORT_B);
                if (!mem_we) begin
                    if (last_grant == PORT_A) rdata_a_nxt = mem_rdata;
                    else                      rdata_b_nxt = mem_rdata;
                end
            end
            default: ;
        endcase
    end

`ifdef NANO_ARB_STATS_EN
    always_ff @(posedge ck) begin
        if (!rst) begin
            grant_cnt_a <= '0;
            grant_cnt_b <= '0;
        end else if (state == IDLE && grant_vld) begin
            if (win == PORT_A && grant_cnt_a != 16'hFFFF) grant_cnt_a <= grant_cnt_a + 16'd1;
            if (win == PORT_B && grant_cnt_b != 16'hFFFF) grant_cnt_b <= grant_cnt_b + 16'd1;
        end
    end
`endif

endmodule
